// File: rtl/sram_burst_reader.sv
// sram_burst_reader: descriptor-driven sequential reader for the ext_sram R0 port.
// Issues back-to-back word reads, captures the fixed-latency return data into a
// credit-guarded FIFO and streams it downstream with valid/ready and a last flag.
module sram_burst_reader #(
  parameter int AW         = 26,
  parameter int DW         = 32,
  parameter int LW         = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int READ_LAT   = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_addr,
  input  logic [LW-1:0] cmd_len,
  output logic          sram_rvalid,
  input  logic          sram_rready,
  output logic [AW-1:0] sram_raddr,
  input  logic [DW-1:0] sram_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Descriptor and issue bookkeeping
  logic [AW-1:0] addr_reg;
  logic [LW-1:0] len_reg;
  logic [LW-1:0] issued_reg;
  // Reads in flight plus words held in the FIFO; bounds FIFO occupancy
  logic [CW-1:0] credit_reg;
  logic          done_reg;

  // Latency tag pipe: one stage per cycle of SRAM read latency
  logic pipe_valid_reg [READ_LAT];
  logic pipe_last_reg  [READ_LAT];

  // Return-data FIFO
  logic [DW-1:0]         fifo_data_reg [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last_reg;
  logic [PW-1:0]         wr_ptr_reg;
  logic [PW-1:0]         rd_ptr_reg;
  logic [CW-1:0]         count_reg;

  logic cmd_fire;
  logic rd_fire;
  logic out_fire;
  logic last_issue;
  logic push;
  logic pop;

  // Handshake and status decode
  always_comb begin
    cmd_ready   = (state_reg == IDLE);
    busy        = (state_reg != IDLE);
    cmd_fire    = cmd_valid & cmd_ready;
    sram_rvalid = (state_reg == ISSUE) && (issued_reg < len_reg) &&
                  (credit_reg < CW'(FIFO_DEPTH));
    sram_raddr  = addr_reg;
    rd_fire     = sram_rvalid & sram_rready;
    last_issue  = (issued_reg == (len_reg - LW'(1)));
    out_valid   = (count_reg != '0);
    out_data    = fifo_data_reg[rd_ptr_reg];
    out_last    = out_valid & fifo_last_reg[rd_ptr_reg];
    out_fire    = out_valid & out_ready;
    push        = pipe_valid_reg[READ_LAT-1];
    pop         = out_fire;
    done        = done_reg;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (cmd_valid && (cmd_len != '0)) state_next = ISSUE;
      ISSUE:   if (rd_fire && last_issue)        state_next = DRAIN;
      DRAIN:   if (out_fire && out_last)         state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Descriptor capture, address generation and issue count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg   <= '0;
      len_reg    <= '0;
      issued_reg <= '0;
    end else if (cmd_fire) begin
      addr_reg   <= cmd_addr;
      len_reg    <= cmd_len;
      issued_reg <= '0;
    end else if (rd_fire) begin
      // Natural AW-bit wrap from all-ones back to zero
      addr_reg   <= addr_reg + AW'(1);
      issued_reg <= issued_reg + LW'(1);
    end
  end

  // Credit: +1 per read issued, -1 per word consumed downstream
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_reg <= '0;
    end else begin
      case ({rd_fire, out_fire})
        2'b10:   credit_reg <= credit_reg + CW'(1);
        2'b01:   credit_reg <= credit_reg - CW'(1);
        default: credit_reg <= credit_reg;
      endcase
    end
  end

  // Completion pulse, one cycle after the final word or a zero-length accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) done_reg <= 1'b0;
    else     done_reg <= (cmd_fire && (cmd_len == '0)) ||
                         ((state_reg == DRAIN) && out_fire && out_last);
  end

  genvar gi;
  generate
    for (gi = 0; gi < READ_LAT; gi++) begin : g_lat
      if (gi == 0) begin : g_head
        // First tag stage: marks a read handshake and whether it is the final word
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            pipe_valid_reg[gi] <= 1'b0;
            pipe_last_reg[gi]  <= 1'b0;
          end else begin
            pipe_valid_reg[gi] <= rd_fire;
            pipe_last_reg[gi]  <= rd_fire & last_issue;
          end
        end
      end else begin : g_tail
        // Later tag stages just delay the tag by one cycle
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            pipe_valid_reg[gi] <= 1'b0;
            pipe_last_reg[gi]  <= 1'b0;
          end else begin
            pipe_valid_reg[gi] <= pipe_valid_reg[gi-1];
            pipe_last_reg[gi]  <= pipe_last_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  // Return FIFO: tap of the tag pipe writes sram_rdata, downstream handshake pops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_data_reg[i] <= '0;
      fifo_last_reg <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
    end else begin
      if (push) begin
        fifo_data_reg[wr_ptr_reg] <= sram_rdata;
        fifo_last_reg[wr_ptr_reg] <= pipe_last_reg[READ_LAT-1];
        wr_ptr_reg                <= wr_ptr_reg + PW'(1);
      end
      if (pop) rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_sram_burst_reader.sv
// tb_sram_burst_reader: directed bursts against a behavioural SRAM; expected
// addresses and words are queued at command time and checked by a monitor.
module tb_sram_burst_reader;

  localparam int AW         = 26;
  localparam int DW         = 32;
  localparam int LW         = 16;
  localparam int FIFO_DEPTH = 8;
  localparam int READ_LAT   = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          sram_rvalid;
  logic          sram_rready;
  logic [AW-1:0] sram_raddr;
  logic [DW-1:0] sram_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  sram_burst_reader #(
    .AW(AW), .DW(DW), .LW(LW), .FIFO_DEPTH(FIFO_DEPTH), .READ_LAT(READ_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .sram_rvalid(sram_rvalid), .sram_rready(sram_rready), .sram_raddr(sram_raddr),
    .sram_rdata(sram_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done)
  );

  int checks     = 0;
  int errors     = 0;
  int hs_cnt     = 0;
  int out_cnt    = 0;
  int done_cnt   = 0;
  int rvalid_cnt = 0;
  int rready_rand = 0;

  logic [DW:0]   exp_q[$];       // {last, data}
  logic [AW-1:0] exp_addr_q[$];
  logic [DW:0]   exp_word;
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_addr  = '0;

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    return {a[15:0], a[15:0] ^ 16'hC3A5};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural SRAM: data for a handshake appears for the following cycle
  initial begin : sram_model
    logic          hs;
    logic [AW-1:0] a;
    sram_rready = 1'b1;
    sram_rdata  = '0;
    forever begin
      @(negedge clk);
      hs = sram_rvalid && sram_rready;
      a  = sram_raddr;
      @(posedge clk);
      #1;
      sram_rdata  = hs ? mem_fn(a) : 32'hDEAD_BEEF;
      sram_rready = (rready_rand != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: R0 address scoreboard, R0 hold rule, output word scoreboard
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("r0_hold_valid", 64'(sram_rvalid), 64'd1);
        chk("r0_hold_addr", 64'(sram_raddr), 64'(prev_addr));
      end
      prev_stall = sram_rvalid && !sram_rready;
      prev_addr  = sram_raddr;
      if (sram_rvalid) rvalid_cnt++;
      if (sram_rvalid && sram_rready) begin
        hs_cnt++;
        if (exp_addr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL r0_unexpected: got read at 0x%0h, required no read", sram_raddr);
        end else begin
          chk("r0_addr", 64'(sram_raddr), 64'(exp_addr_q.pop_front()));
        end
      end
      if (out_valid && out_ready) begin
        out_cnt++;
        $display("[tb] out word data=0x%08h last=%0b", out_data, out_last);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected: got word 0x%0h, required none", out_data);
        end else begin
          exp_word = exp_q.pop_front();
          chk("out_data", 64'(out_data), 64'(exp_word[DW-1:0]));
          chk("out_last", 64'(out_last), 64'(exp_word[DW]));
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"},   64'(cmd_ready),   64'd1);
    chk({tag, "_sram_rvalid"}, 64'(sram_rvalid), 64'd0);
    chk({tag, "_sram_raddr"},  64'(sram_raddr),  64'd0);
    chk({tag, "_out_valid"},   64'(out_valid),   64'd0);
    chk({tag, "_out_data"},    64'(out_data),    64'd0);
    chk({tag, "_out_last"},    64'(out_last),    64'd0);
    chk({tag, "_busy"},        64'(busy),        64'd0);
    chk({tag, "_done"},        64'(done),        64'd0);
  endtask

  // Present one descriptor for exactly one clock edge and queue expectations
  task automatic send_cmd(input logic [AW-1:0] a, input logic [LW-1:0] n);
    @(posedge clk);
    #1;
    chk("cmd_ready_before_accept", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = n;
    for (int i = 0; i < int'(n); i++) begin
      logic [AW-1:0] wa;
      wa = a + AW'(i);
      exp_addr_q.push_back(wa);
      exp_q.push_back({(i == int'(n) - 1), mem_fn(wa)});
    end
    $display("[tb] cmd addr=0x%07h len=%0d", a, n);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL wait_done: got no done pulse, required one within %0d cycles", budget);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int hs0, d0, rv0, o0;
    bit reached;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // 1: short burst at full rate
    hs0 = hs_cnt;
    d0  = done_cnt;
    send_cmd(26'h100, 16'd4);
    chk("t1_first_rvalid", 64'(sram_rvalid), 64'd1);
    chk("t1_first_addr", 64'(sram_raddr), 64'h100);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_cmd_ready", 64'(cmd_ready), 64'd0);
    @(posedge clk); #1;
    chk("t1_addr1", 64'(sram_raddr), 64'h101);
    chk("t1_out_valid_early", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("t1_out_valid_latency", 64'(out_valid), 64'd1);
    chk("t1_hs_back_to_back", 64'(hs_cnt - hs0), 64'd2);
    wait_done(50);
    repeat (3) @(posedge clk); #1;
    chk("t1_hs_total", 64'(hs_cnt - hs0), 64'd4);
    chk("t1_done_count", 64'(done_cnt - d0), 64'd1);
    chk("t1_idle", 64'(busy), 64'd0);

    // 2: downstream stalled, credit caps reads at FIFO depth
    out_ready = 1'b0;
    hs0 = hs_cnt;
    send_cmd(26'h200, 16'd20);
    repeat (30) @(posedge clk); #1;
    chk("t2_hs_capped", 64'(hs_cnt - hs0), 64'd8);
    chk("t2_rvalid_stalled", 64'(sram_rvalid), 64'd0);
    chk("t2_out_valid_full", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    wait_done(200);
    repeat (2) @(posedge clk); #1;
    chk("t2_hs_total", 64'(hs_cnt - hs0), 64'd20);
    chk("t2_words_left", 64'(exp_q.size()), 64'd0);

    // 3: random SRAM back-pressure
    rready_rand = 1;
    hs0 = hs_cnt;
    send_cmd(26'h0, 16'd16);
    wait_done(1000);
    rready_rand = 0;
    repeat (2) @(posedge clk); #1;
    chk("t3_hs_total", 64'(hs_cnt - hs0), 64'd16);
    chk("t3_addrs_left", 64'(exp_addr_q.size()), 64'd0);
    chk("t3_words_left", 64'(exp_q.size()), 64'd0);

    // 4: zero-length descriptor
    d0  = done_cnt;
    rv0 = rvalid_cnt;
    send_cmd(26'h55, 16'd0);
    chk("t4_done_pulse", 64'(done), 64'd1);
    chk("t4_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk("t4_done_cleared", 64'(done), 64'd0);
    repeat (5) @(posedge clk); #1;
    chk("t4_no_reads", 64'(rvalid_cnt - rv0), 64'd0);
    chk("t4_done_count", 64'(done_cnt - d0), 64'd1);

    // 5: address wrap at the top of the address space
    hs0 = hs_cnt;
    send_cmd(26'h3FFFFFE, 16'd4);
    chk("t5_addr0", 64'(sram_raddr), 64'h3FFFFFE);
    @(posedge clk); #1;
    chk("t5_addr1", 64'(sram_raddr), 64'h3FFFFFF);
    @(posedge clk); #1;
    chk("t5_addr2", 64'(sram_raddr), 64'h0000000);
    @(posedge clk); #1;
    chk("t5_addr3", 64'(sram_raddr), 64'h0000001);
    wait_done(50);
    repeat (2) @(posedge clk); #1;
    chk("t5_hs_total", 64'(hs_cnt - hs0), 64'd4);

    // 6: reset in the middle of a burst, then a fresh burst
    o0 = out_cnt;
    reached = 1'b0;
    send_cmd(26'h0, 16'd16);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (out_cnt - o0 >= 5) begin
        reached = 1'b1;
        break;
      end
    end
    chk("t6_reached_5_words", 64'(reached), 64'd1);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("t6_reset");
    exp_q.delete();
    exp_addr_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    o0 = out_cnt;
    send_cmd(26'h40, 16'd2);
    wait_done(50);
    repeat (4) @(posedge clk); #1;
    chk("t6_words_after_reset", 64'(out_cnt - o0), 64'd2);
    chk("t6_words_left", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
